// File: rtl/ram_wave_reader.sv
// Streams a block of words from an Avalon-MM RAM slave (read latency 1) onto a
// valid/ready output, one word per READ/CAPTURE/HOLD round, with optional looping.
module ram_wave_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              loop_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] last_idx_r;
    logic [ADDR_W-1:0] index_r;
    logic              loop_r;

    logic [ADDR_W-1:0] len_m1_s;
    logic [ADDR_W-1:0] index_inc_s;
    logic              len_zero_s;
    logic              last_s;

    // Index arithmetic; a length of 2^ADDR_W has zero low bits, so minus one wraps to the top index.
    always_comb begin
        len_m1_s    = length[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
        len_zero_s  = (length == {(ADDR_W+1){1'b0}});
        index_inc_s = index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        last_s      = (index_r == last_idx_r);
    end

    // Transfer FSM; every output is a register updated together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            base_r         <= {ADDR_W{1'b0}};
            last_idx_r     <= {ADDR_W{1'b0}};
            index_r        <= {ADDR_W{1'b0}};
            loop_r         <= 1'b0;
            avm_address    <= {ADDR_W{1'b0}};
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            out_data       <= {DATA_W{1'b0}};
            out_valid      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_r        <= IDLE;
                avm_chipselect <= 1'b0;
                avm_read       <= 1'b0;
                out_valid      <= 1'b0;
                busy           <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            if (!len_zero_s) begin
                                base_r         <= base_addr;
                                last_idx_r     <= len_m1_s;
                                loop_r         <= loop_en;
                                index_r        <= {ADDR_W{1'b0}};
                                avm_address    <= base_addr;
                                avm_chipselect <= 1'b1;
                                avm_read       <= 1'b1;
                                busy           <= 1'b1;
                                state_r        <= READ;
                            end else begin
                                done <= 1'b1;
                            end
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    READ: begin
                        if (!avm_waitrequest) begin
                            avm_chipselect <= 1'b0;
                            avm_read       <= 1'b0;
                            state_r        <= CAPTURE;
                        end else begin
                            state_r <= READ;
                        end
                    end
                    CAPTURE: begin
                        out_data  <= avm_readdata;
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (!last_s) begin
                                index_r        <= index_inc_s;
                                avm_address    <= base_r + index_inc_s;
                                avm_chipselect <= 1'b1;
                                avm_read       <= 1'b1;
                                state_r        <= READ;
                            end else if (loop_r) begin
                                index_r        <= {ADDR_W{1'b0}};
                                avm_address    <= base_r;
                                avm_chipselect <= 1'b1;
                                avm_read       <= 1'b1;
                                state_r        <= READ;
                            end else begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= IDLE;
                            end
                        end else begin
                            state_r <= HOLD;
                        end
                    end
                    default: begin
                        avm_chipselect <= 1'b0;
                        avm_read       <= 1'b0;
                        out_valid      <= 1'b0;
                        busy           <= 1'b0;
                        state_r        <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_wave_reader.sv
// Directed bench for ram_wave_reader: table of block transfers plus hand-written
// backpressure, stall, loop/abort, zero-length and mid-transfer reset sequences.
module tb_ram_wave_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        loop_en;
    logic        abort;
    logic [11:0] avm_address;
    logic        avm_chipselect;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [11:0] rd_q[$];
    logic [31:0] out_q[$];

    ram_wave_reader #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .loop_en(loop_en), .abort(abort),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [11:0] a);
        return {20'hCAFE0, a};
    endfunction

    // RAM slave model: data valid exactly one cycle after an accepted read, junk otherwise
    always @(posedge clk) begin
        if (avm_read && avm_chipselect && !avm_waitrequest)
            avm_readdata <= ram_word(avm_address);
        else
            avm_readdata <= 32'hDEAD_BEEF;
    end

    // Observation of accepted reads, accepted output words and done pulses
    always @(posedge clk) begin
        if (!reset) begin
            if (avm_read && avm_chipselect && !avm_waitrequest) rd_q.push_back(avm_address);
            if (out_valid && out_ready) out_q.push_back(out_data);
            if (done) done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_read"}, {63'd0, avm_read}, 64'd0);
        check({name, "_cs"}, {63'd0, avm_chipselect}, 64'd0);
        check({name, "_addr"}, {52'd0, avm_address}, 64'd0);
        check({name, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({name, "_data"}, {32'd0, out_data}, 64'd0);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_done"}, {63'd0, done}, 64'd0);
    endtask

    task automatic clear_obs();
        rd_q.delete();
        out_q.delete();
        done_cnt = 0;
    endtask

    typedef struct {
        logic [11:0] base;
        logic [12:0] len;
        logic [11:0] exp_first;
        logic [11:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [11:0] ea;
        logic [31:0] held;
        logic [11:0] loop_exp[6];
        int c;
        bit got;

        vecs[0] = '{12'h010, 13'd3, 12'h010, 12'h012};
        vecs[1] = '{12'hFFE, 13'd4, 12'hFFE, 12'h001};
        vecs[2] = '{12'h000, 13'd1, 12'h000, 12'h000};
        vecs[3] = '{12'hFFF, 13'd2, 12'hFFF, 12'h000};
        vecs[4] = '{12'h800, 13'd5, 12'h800, 12'h804};
        loop_exp = '{12'h010, 12'h011, 12'h010, 12'h011, 12'h010, 12'h011};

        reset = 1'b1; start = 1'b0; base_addr = 12'h000; length = 13'd0;
        loop_en = 1'b0; abort = 1'b0; avm_waitrequest = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check_idle_outputs("in_reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("after_reset");

        // Table-driven block transfers, full throughput
        for (int k = 0; k < 5; k++) begin
            clear_obs();
            base_addr = vecs[k].base; length = vecs[k].len; loop_en = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            check("blk_busy_start", {63'd0, busy}, 64'd1);
            got = 1'b0; c = 0;
            while (!got && c < 40) begin
                tick(); c++;
                if (done) got = 1'b1;
            end
            check("blk_done_seen", {63'd0, got}, 64'd1);
            check("blk_cycles", c, 3 * int'(vecs[k].len));
            check("blk_busy_at_done", {63'd0, busy}, 64'd0);
            tick();
            check("blk_done_pulse", {63'd0, done}, 64'd0);
            check("blk_done_cnt", done_cnt, 1);
            check("blk_nreads", rd_q.size(), int'(vecs[k].len));
            check("blk_nwords", out_q.size(), int'(vecs[k].len));
            if (rd_q.size() > 0) begin
                check("blk_first_addr", {52'd0, rd_q[0]}, {52'd0, vecs[k].exp_first});
                check("blk_last_addr", {52'd0, rd_q[rd_q.size()-1]}, {52'd0, vecs[k].exp_last});
            end
            for (int i = 0; i < int'(vecs[k].len); i++) begin
                ea = vecs[k].base + 12'(i);
                if (i < rd_q.size()) check("blk_addr", {52'd0, rd_q[i]}, {52'd0, ea});
                if (i < out_q.size()) check("blk_data", {32'd0, out_q[i]}, {32'd0, ram_word(ea)});
            end
        end

        // Backpressure in HOLD, then waitrequest stall in READ
        clear_obs();
        out_ready = 1'b0; base_addr = 12'h100; length = 13'd2; start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!out_valid && c < 20) begin tick(); c++; end
        check("bp_valid_seen", {63'd0, out_valid}, 64'd1);
        held = out_data;
        check("bp_data", {32'd0, held}, {32'd0, ram_word(12'h100)});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data_stable", {32'd0, out_data}, {32'd0, held});
            check("bp_valid_stable", {63'd0, out_valid}, 64'd1);
            check("bp_no_read", {63'd0, avm_read}, 64'd0);
        end
        check("bp_nreads", rd_q.size(), 1);
        out_ready = 1'b1;
        tick();
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_read", {63'd0, avm_read}, 64'd1);
            check("stall_cs", {63'd0, avm_chipselect}, 64'd1);
            check("stall_addr", {52'd0, avm_address}, 64'h101);
            tick();
        end
        check("stall_nreads", rd_q.size(), 1);
        avm_waitrequest = 1'b0;
        got = 1'b0; c = 0;
        while (!got && c < 20) begin tick(); c++; if (done) got = 1'b1; end
        check("stall_done_seen", {63'd0, got}, 64'd1);
        check("stall_nwords", out_q.size(), 2);
        if (out_q.size() == 2) check("stall_data", {32'd0, out_q[1]}, {32'd0, ram_word(12'h101)});

        // Looping block; a mid-transfer start with new parameters must be ignored
        tick();
        clear_obs();
        base_addr = 12'h010; length = 13'd2; loop_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) begin
                start = 1'b1; base_addr = 12'h700; length = 13'd1; loop_en = 1'b0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("loop_nreads", rd_q.size(), 7);
        for (int i = 0; i < 6; i++)
            if (i < rd_q.size()) check("loop_addr", {52'd0, rd_q[i]}, {52'd0, loop_exp[i]});
        check("loop_no_done", done_cnt, 0);
        check("loop_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1; start = 1'b1; length = 13'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_read", {63'd0, avm_read}, 64'd0);
        check("abort_cs", {63'd0, avm_chipselect}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        tick();
        check("abort_done_next", {63'd0, done}, 64'd0);
        check("abort_start_ignored", {63'd0, busy}, 64'd0);
        tick();
        check("abort_done_cnt", done_cnt, 0);

        // Zero-length start: done one cycle later, no Avalon activity
        clear_obs();
        length = 13'd0; loop_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_busy", {63'd0, busy}, 64'd0);
        check("zero_read", {63'd0, avm_read}, 64'd0);
        tick();
        check("zero_done_pulse", {63'd0, done}, 64'd0);
        check("zero_nreads", rd_q.size(), 0);

        // Asynchronous reset while in CAPTURE
        clear_obs();
        base_addr = 12'h020; length = 13'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("cap_busy", {63'd0, busy}, 64'd1);
        check("cap_read_low", {63'd0, avm_read}, 64'd0);
        check("cap_valid_low", {63'd0, out_valid}, 64'd0);
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_reset");
        tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");
        for (int i = 0; i < 6; i++) tick();
        check("post_reset_nreads", rd_q.size(), 1);
        check("post_reset_nwords", out_q.size(), 0);
        check("post_reset_no_done", done_cnt, 0);
        check("post_reset_busy", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_wave_reader.md
RAM_WAVE_READER -- requirements
Module: ram_wave_reader

Interface
REQ-001 Parameter ADDR_W, default 12: word-address width of the target RAM slave, giving 4096 words.
REQ-002 Parameter DATA_W, default 32: data width of the RAM slave and of the output stream.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_W  first word address of the transfer.
REQ-007 length  in  ADDR_W+1  number of words to read (0..4096).
REQ-008 loop_en  in  1  at end of block, restart from base_addr instead of finishing.
REQ-009 abort  in  1  terminates any transfer; has priority over every other input.
REQ-010 avm_address  out  ADDR_W  Avalon-MM word address.
REQ-011 avm_chipselect  out  1  Avalon-MM chip select.
REQ-012 avm_read  out  1  Avalon-MM read strobe.
REQ-013 avm_waitrequest  in  1  slave stall; tie low for the on-chip RAM.
REQ-014 avm_readdata  in  DATA_W  read data, valid exactly 1 cycle after an accepted read (fixed latency 1).
REQ-015 out_data  out  DATA_W  stream data.
REQ-016 out_valid  out  1  out_data is valid.
REQ-017 out_ready  in  1  downstream accepts the word when out_valid and out_ready are both 1.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse on normal completion.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, READ, CAPTURE, HOLD.
REQ-021 IDLE: on start with length≠0, latch base_addr, length and loop_en, clear the index, and enter READ.
REQ-022 IDLE: on start with length=0, pulse done on the next cycle and remain in IDLE.
REQ-023 READ: drive avm_chipselect=avm_read=1 and avm_address=(base+index) mod 2^ADDR_W.
REQ-024 READ: while avm_waitrequest=1, hold all Avalon outputs stable; when avm_waitrequest=0, the read is accepted and the FSM enters CAPTURE.
REQ-025 avm_read and avm_chipselect SHALL be 0 in every state except READ; the block never writes.
REQ-026 CAPTURE: register avm_readdata into out_data, set out_valid=1, and enter HOLD.
REQ-027 HOLD: out_valid and out_data stay stable until out_ready=1.
REQ-028 HOLD, on accept, not the last word: out_valid=0, increment the index, enter READ.
REQ-029 HOLD, on accept, last word (index=length-1), loop_en latched 1: out_valid=0, clear the index, enter READ; no done pulse.
REQ-030 HOLD, on accept, last word, loop_en latched 0: out_valid=0, enter IDLE, pulse done for exactly one cycle.
REQ-031 Address wrap: base+index past 2^ADDR_W-1 SHALL wrap to 0, with no error.
REQ-032 start while busy SHALL be ignored; latched parameters cannot change mid-transfer.
REQ-033 abort in any state SHALL enter IDLE on the next edge with out_valid=0 and no done pulse; abort and start in the same cycle means abort wins.
REQ-034 Throughput SHALL be at most one word per 3 cycles with waitrequest=0 and out_ready=1.

Reset
REQ-035 During reset, and in the first cycle after it:
- state=IDLE; index=0;
- avm_read=avm_chipselect=0; avm_address=0;
- out_valid=0; out_data=0; busy=0; done=0.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer immediately with no done pulse; an already-issued read is discarded.

Verification
REQ-037 Basic block: base=0x010, length=3, loop_en=0, out_ready=1, waitrequest=0 -> reads at 0x010, 0x011, 0x012; 3 words out in RAM order; done pulses once; busy falls the same cycle.
REQ-038 Wrap: base=0xFFE, length=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 Backpressure and stall:
- out_ready low for 5 cycles in HOLD -> out_data stable, no new read issued;
- waitrequest high for 3 cycles in READ -> address and read held stable;
- output data correct in both cases.
REQ-040 Loop, then abort:
- length=2, loop_en=1 -> address sequence 0x010, 0x011, 0x010, …, never done;
- abort -> IDLE next cycle, out_valid=0, no done.
REQ-041 Corner cases:
- length=0 start -> done 1 cycle later, no Avalon read;
- start while busy -> ignored;
- reset asserted in CAPTURE -> all outputs at reset values asynchronously.
